// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter slice.
package pine_mem_pkg;

    localparam int unsigned ADDR_W      = 20;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned STARVE_W    = 4;
    localparam int unsigned DEF_TIMEOUT = 15;
    localparam int unsigned DEF_FSTARVE = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic REQ_F = 1'b0;
    localparam logic REQ_X = 1'b1;

    // Memory command captured at grant time
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt,
                                                       input logic [STARVE_W-1:0] lim);
        return (cnt >= lim) ? cnt : cnt + STARVE_W'(1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_arbiter_if;
    import pine_mem_pkg::*;

    logic              rqf;
    logic [ADDR_W-1:0] adf;
    logic              akf;
    logic              rqx;
    logic              rwx;
    logic [ADDR_W-1:0] adx;
    logic [DATA_W-1:0] dwx;
    logic              akx;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              rqm;
    logic              rwm;
    logic [ADDR_W-1:0] adm;
    logic [DATA_W-1:0] dwm;
    logic              akm;
    logic [DATA_W-1:0] drm;

    // Arbiter view
    modport slave (
        input  rqf, adf, rqx, rwx, adx, dwx, akm, drm,
        output akf, akx, rdata, err, rqm, rwm, adm, dwm
    );

    // Requesters plus memory view
    modport master (
        output rqf, adf, rqx, rwx, adx, dwx, akm, drm,
        input  akf, akx, rdata, err, rqm, rwm, adm, dwm
    );

endinterface

// File: rtl/mem_arbiter_wdog.sv
// Bus watchdog: counts enabled cycles after a clear and flags TIMEOUT-1.
module mem_wdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (read-only) and execute (read/write),
// execute first, with a starvation guard for fetch and a bus-timeout watchdog.
module mem_arbiter
    import pine_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned FSTARVE = DEF_FSTARVE
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(FSTARVE);

    state_e              state_q, state_d;
    mem_cmd_t            cmd_q, cmd_d;
    logic                win_q, win_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                rqm_q, rqm_d;
    logic                akf_q, akf_d;
    logic                akx_q, akx_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                grant_f;
    logic                wd_clr, wd_en, wd_expire;

    mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        win_d    = win_q;
        starve_d = starve_q;
        rqm_d    = rqm_q;
        rdata_d  = rdata_q;
        akf_d    = 1'b0;
        akx_d    = 1'b0;
        err_d    = 1'b0;
        wd_clr   = 1'b0;
        wd_en    = 1'b0;
        // Fetch wins only when alone or once execute has used up its streak
        grant_f  = bus.rqf && (!bus.rqx || (starve_q == STARVE_LIM));

        case (state_q)
            IDLE: begin
                if (bus.rqf || bus.rqx) begin
                    rqm_d   = 1'b1;
                    wd_clr  = 1'b1;
                    state_d = BUSY;
                    if (grant_f) begin
                        win_d      = REQ_F;
                        cmd_d.rw   = RW_READ;
                        cmd_d.addr = bus.adf;
                        starve_d   = '0;
                    end else begin
                        win_d       = REQ_X;
                        cmd_d.rw    = bus.rwx;
                        cmd_d.addr  = bus.adx;
                        cmd_d.wdata = bus.dwx;
                        if (bus.rqf) begin
                            starve_d = starve_inc(starve_q, STARVE_LIM);
                        end
                    end
                end
            end
            BUSY: begin
                // A memory ack on the expiry edge still completes normally
                if (bus.akm || wd_expire) begin
                    rqm_d   = 1'b0;
                    akf_d   = (win_q == REQ_F);
                    akx_d   = (win_q == REQ_X);
                    err_d   = !bus.akm;
                    state_d = RESP;
                    if (cmd_q.rw == RW_READ) begin
                        rdata_d = bus.akm ? bus.drm : '1;
                    end
                end else begin
                    wd_en = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            win_q    <= REQ_F;
            starve_q <= '0;
            rqm_q    <= 1'b0;
            akf_q    <= 1'b0;
            akx_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            win_q    <= win_d;
            starve_q <= starve_d;
            rqm_q    <= rqm_d;
            akf_q    <= akf_d;
            akx_q    <= akx_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.rqm   = rqm_q;
    assign bus.rwm   = cmd_q.rw;
    assign bus.adm   = cmd_q.addr;
    assign bus.dwm   = cmd_q.wdata;
    assign bus.akf   = akf_q;
    assign bus.akx   = akx_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_mem_arbiter;
    import pine_mem_pkg::*;

    localparam int unsigned TO = 15;
    localparam int unsigned FS = 3;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TO), .FSTARVE(FS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f, x, rw;
        logic [19:0] af, ax;
        logic [15:0] dw;
        int          wt;
        logic [15:0] dr;
        logic        e_x, e_rw;
        logic [19:0] e_adm;
        logic [15:0] e_dwm;
        int          e_busy;
        logic        e_err;
        logic [15:0] e_rdata;
    } vec_t;

    typedef struct {
        logic        gf, gx, rqm_g, rwm, rqm_lost, rw_moved, rqm_r, err, ack_after, err_after;
        logic [19:0] adm;
        logic [15:0] dwm, rdata;
        int          busy;
    } obs_t;

    int checks = 0;
    int passes = 0;

    int          m_starve;
    logic [15:0] m_rdata;
    logic [15:0] m_dwm;

    vec_t tbl [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic f, input logic x, input logic rw,
                                input logic [19:0] af, input logic [19:0] ax,
                                input logic [15:0] dw, input int wt, input logic [15:0] dr);
        vec_t v;
        v.f = f; v.x = x; v.rw = rw; v.af = af; v.ax = ax; v.dw = dw; v.wt = wt; v.dr = dr;
        v.e_x = 1'b0; v.e_rw = 1'b0; v.e_adm = '0; v.e_dwm = '0;
        v.e_busy = 0; v.e_err = 1'b0; v.e_rdata = '0;
        return v;
    endfunction

    function automatic vec_t with_exp(input vec_t v, input logic e_x, input logic e_rw,
                                      input logic [19:0] e_adm, input logic [15:0] e_dwm,
                                      input int e_busy, input logic e_err, input logic [15:0] e_rdata);
        vec_t r;
        r = v;
        r.e_x = e_x; r.e_rw = e_rw; r.e_adm = e_adm; r.e_dwm = e_dwm;
        r.e_busy = e_busy; r.e_err = e_err; r.e_rdata = e_rdata;
        return r;
    endfunction

    // Transaction-level reference: who wins, how long the bus is held, what comes back
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   take_f;
        bit   acked;
        r      = v;
        take_f = v.f && (!v.x || (m_starve == int'(FS)));
        acked  = (v.wt < int'(TO));
        r.e_x   = !take_f;
        r.e_rw  = take_f ? RW_READ : v.rw;
        r.e_adm = take_f ? v.af : v.ax;
        if (!take_f) m_dwm = v.dw;
        r.e_dwm = m_dwm;
        if (take_f) m_starve = 0;
        else if (v.f) m_starve = (m_starve < int'(FS)) ? m_starve + 1 : int'(FS);
        r.e_busy = acked ? v.wt + 1 : int'(TO);
        r.e_err  = !acked;
        if (r.e_rw == RW_READ) m_rdata = acked ? v.dr : 16'hFFFF;
        r.e_rdata = m_rdata;
        return r;
    endfunction

    // Drives one request from IDLE through grant, BUSY and RESP back to IDLE
    task automatic txn(input vec_t v, output obs_t o);
        int busy;
        bus.rqf = v.f; bus.rqx = v.x; bus.rwx = v.rw;
        bus.adf = v.af; bus.adx = v.ax; bus.dwx = v.dw; bus.akm = 1'b0;
        @(posedge clk); #1;
        o.rqm_g = bus.rqm; o.adm = bus.adm; o.rwm = bus.rwm; o.dwm = bus.dwm;
        bus.adf = 20'($urandom); bus.adx = 20'($urandom);
        bus.dwx = 16'($urandom); bus.rwx = 1'($urandom);
        o.rqm_lost = 1'b0; o.rw_moved = 1'b0; busy = 0;
        do begin
            busy++;
            if (!bus.rqm) o.rqm_lost = 1'b1;
            if (bus.rwm !== o.rwm) o.rw_moved = 1'b1;
            bus.akm = (busy == v.wt + 1);
            bus.drm = bus.akm ? v.dr : 16'($urandom);
            @(posedge clk); #1;
            bus.akm = 1'b0;
        end while (!(bus.akf || bus.akx) && busy < 40);
        o.busy = busy; o.gf = bus.akf; o.gx = bus.akx;
        o.err = bus.err; o.rdata = bus.rdata; o.rqm_r = bus.rqm;
        bus.rqf = 1'b0; bus.rqx = 1'b0;
        @(posedge clk); #1;
        o.ack_after = bus.akf | bus.akx;
        o.err_after = bus.err;
    endtask

    task automatic verify(input string tag, input vec_t v, input obs_t o);
        check($sformatf("%s winner_x", tag), 32'(o.gx), 32'(v.e_x));
        check($sformatf("%s winner_f", tag), 32'(o.gf), 32'(!v.e_x));
        check($sformatf("%s rqm_at_grant", tag), 32'(o.rqm_g), 32'd1);
        check($sformatf("%s adm", tag), 32'(o.adm), 32'(v.e_adm));
        check($sformatf("%s rwm", tag), 32'(o.rwm), 32'(v.e_rw));
        check($sformatf("%s dwm", tag), 32'(o.dwm), 32'(v.e_dwm));
        check($sformatf("%s busy_cycles", tag), 32'(o.busy), 32'(v.e_busy));
        check($sformatf("%s rqm_rwm_steady", tag), 32'({o.rqm_lost, o.rw_moved}), 32'd0);
        check($sformatf("%s rqm_in_resp", tag), 32'(o.rqm_r), 32'd0);
        check($sformatf("%s err", tag), 32'(o.err), 32'(v.e_err));
        check($sformatf("%s rdata", tag), 32'(o.rdata), 32'(v.e_rdata));
        check($sformatf("%s ack_one_cycle", tag), 32'({o.ack_after, o.err_after}), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check($sformatf("%s ctrl", tag), 32'({bus.rqm, bus.rwm, bus.akf, bus.akx, bus.err}), 32'd0);
        check($sformatf("%s adm", tag), 32'(bus.adm), 32'd0);
        check($sformatf("%s dwm", tag), 32'(bus.dwm), 32'd0);
        check($sformatf("%s rdata", tag), 32'(bus.rdata), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        bus.rqf = 1'b0; bus.rqx = 1'b0; bus.akm = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        m_starve = 0; m_rdata = '0; m_dwm = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL sim_time_limit: got no finish, expected finish before limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        obs_t o;
        int   sel;
        int   gap;

        bus.rqf = 1'b0; bus.rqx = 1'b0; bus.rwx = 1'b0;
        bus.adf = '0; bus.adx = '0; bus.dwx = '0;
        bus.akm = 1'b0; bus.drm = '0;
        rst = 1'b1;

        tbl[0]  = with_exp(mk(0, 1, 1, 20'h0, 20'h12345, 16'hBEEF, 0, 16'h0000), 1, 1, 20'h12345, 16'hBEEF, 1, 0, 16'h0000);
        tbl[1]  = with_exp(mk(1, 0, 0, 20'h00100, 20'h0, 16'h0, 4, 16'hA5A5), 0, 0, 20'h00100, 16'hBEEF, 5, 0, 16'hA5A5);
        tbl[2]  = with_exp(mk(0, 1, 0, 20'h0, 20'h0ABCD, 16'h1111, 255, 16'h5555), 1, 0, 20'h0ABCD, 16'h1111, 15, 1, 16'hFFFF);
        tbl[3]  = with_exp(mk(0, 1, 0, 20'h0, 20'h00042, 16'h2222, 14, 16'h1234), 1, 0, 20'h00042, 16'h2222, 15, 0, 16'h1234);
        tbl[4]  = with_exp(mk(0, 1, 1, 20'h0, 20'hFFFFF, 16'h0F0F, 1, 16'h9999), 1, 1, 20'hFFFFF, 16'h0F0F, 2, 0, 16'h1234);
        tbl[5]  = with_exp(mk(0, 1, 1, 20'h0, 20'h00007, 16'h7777, 255, 16'h9999), 1, 1, 20'h00007, 16'h7777, 15, 1, 16'h1234);
        tbl[6]  = with_exp(mk(1, 1, 1, 20'hAAAAA, 20'hBBBBB, 16'h3333, 0, 16'h4444), 1, 1, 20'hBBBBB, 16'h3333, 1, 0, 16'h1234);
        tbl[7]  = with_exp(mk(1, 1, 1, 20'hAAAAA, 20'hBBBBB, 16'h3333, 0, 16'h4444), 1, 1, 20'hBBBBB, 16'h3333, 1, 0, 16'h1234);
        tbl[8]  = with_exp(mk(1, 1, 1, 20'hAAAAA, 20'hBBBBB, 16'h3333, 0, 16'h4444), 1, 1, 20'hBBBBB, 16'h3333, 1, 0, 16'h1234);
        tbl[9]  = with_exp(mk(1, 1, 1, 20'hAAAAA, 20'hBBBBB, 16'h3333, 0, 16'h4444), 0, 0, 20'hAAAAA, 16'h3333, 1, 0, 16'h4444);
        tbl[10] = with_exp(mk(1, 1, 1, 20'hAAAAA, 20'hBBBBB, 16'h3333, 0, 16'h4444), 1, 1, 20'hBBBBB, 16'h3333, 1, 0, 16'h4444);
        tbl[11] = with_exp(mk(1, 1, 1, 20'hAAAAA, 20'hBBBBB, 16'h3333, 0, 16'h4444), 1, 1, 20'hBBBBB, 16'h3333, 1, 0, 16'h4444);
        tbl[12] = with_exp(mk(1, 1, 1, 20'hAAAAA, 20'hBBBBB, 16'h3333, 0, 16'h4444), 1, 1, 20'hBBBBB, 16'h3333, 1, 0, 16'h4444);
        tbl[13] = with_exp(mk(1, 1, 1, 20'hAAAAA, 20'hBBBBB, 16'h3333, 0, 16'h5555), 0, 0, 20'hAAAAA, 16'h3333, 1, 0, 16'h5555);

        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            txn(tbl[i], o);
            verify($sformatf("vec%0d", i), tbl[i], o);
        end

        // Late memory ack after a timeout must be ignored
        do_reset("reset_late");
        v = model(mk(0, 1, RW_READ, 20'h0, 20'h0CAFE, 16'h5A5A, 255, 16'h7777));
        txn(v, o);
        verify("late_timeout", v, o);
        @(posedge clk); #1;
        bus.akm = 1'b1; bus.drm = 16'h2222;
        @(posedge clk); #1;
        bus.akm = 1'b0;
        check("late_akm ack", 32'({bus.akf, bus.akx, bus.err}), 32'd0);
        check("late_akm rqm", 32'(bus.rqm), 32'd0);
        check("late_akm rdata", 32'(bus.rdata), 32'hFFFF);
        @(posedge clk); #1;
        check("late_akm ack_next", 32'({bus.akf, bus.akx, bus.err, bus.rqm}), 32'd0);

        // Reset abandons a transaction and clears the starvation count
        do_reset("reset_mid_pre");
        for (int k = 0; k < 3; k++) begin
            v = model(mk(1, 1, RW_WRITE, 20'h11111, 20'h22222, 16'h3C3C, 0, 16'h0));
            txn(v, o);
            verify($sformatf("mid_pre%0d", k), v, o);
        end
        bus.rqf = 1'b1; bus.rqx = 1'b1; bus.rwx = 1'b1;
        bus.adf = 20'h33333; bus.adx = 20'h44444; bus.dwx = 16'h6666; bus.akm = 1'b0;
        @(posedge clk); #1;
        check("mid_grant adm", 32'(bus.adm), 32'h33333);
        check("mid_grant rqm", 32'(bus.rqm), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("mid_busy_async");
        @(posedge clk); #1;
        check_zero("mid_busy_held");
        @(negedge clk);
        rst = 1'b0;
        m_starve = 0; m_rdata = '0; m_dwm = '0;
        for (int k = 0; k < 4; k++) begin
            v = model(mk(1, 1, RW_WRITE, 20'h55555, 20'h66666, 16'h7A7A, 0, 16'h0));
            txn(v, o);
            verify($sformatf("mid_post%0d", k), v, o);
            if (k == 0) check("mid_post first_grant_x", 32'(o.gx), 32'd1);
            if (k == 3) check("mid_post fourth_grant_f", 32'(o.gf), 32'd1);
        end

        // Randomized traffic against the reference model
        do_reset("reset_rand");
        for (int n = 0; n < 60; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                bus.akm = 1'($urandom); bus.drm = 16'($urandom);
                @(posedge clk); #1;
                bus.akm = 1'b0;
                check($sformatf("rand%0d idle", n), 32'({bus.rqm, bus.akf, bus.akx, bus.err}), 32'd0);
            end
            sel = $urandom_range(1, 3);
            v = mk(sel[0], sel[1], 1'($urandom), 20'($urandom), 20'($urandom), 16'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 18)) : int'($urandom_range(0, 5)),
                   16'($urandom));
            v = model(v);
            txn(v, o);
            verify($sformatf("rand%0d", n), v, o);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
